// File: rtl/store_buffer_ctrl.sv
// Posted-write buffer between the MEM-stage store path and the system bridge.
// Stores queue in a circular FIFO with tail merging; loads share the bridge port and take priority over draining.
module store_buffer_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_we,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_grant,
  output logic             ld_stall,
  input  logic             drain_req,
  output logic             drain_busy,
  output logic             bus_wvalid,
  output logic [31:0]      bus_addr,
  output logic [3:0]       bus_we,
  output logic [31:0]      bus_wdata,
  input  logic             bus_wready,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  logic [29:0]      ent_addr  [DEPTH];
  logic [3:0]       ent_we    [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_m1;
  logic [PTR_W:0]   count_q;

  logic full;
  logic conflict;
  logic deq;
  logic enq;
  logic merge_hit;

  // Low address bits only select lanes, which arrive pre-shifted in st_we.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign tail_m1 = tail - PTR_W'(1);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == ld_addr[31:2])) conflict = 1'b1;
    end
    conflict = conflict && ld_valid;
  end

  assign ld_grant   = ld_valid && !conflict && !full;
  assign ld_stall   = ld_valid && !ld_grant;
  assign bus_wvalid = !empty && !ld_grant;
  assign deq        = bus_wvalid && bus_wready;
  assign drain_busy = drain_req && !empty;

  // The presented head must stay stable, so a store to it allocates instead of merging.
  assign merge_hit = st_valid && !empty
                     && (st_addr[31:2] == ent_addr[tail_m1])
                     && ((tail_m1 != head) || !bus_wvalid);

  assign enq      = st_valid && !full && !merge_hit;
  assign st_ready = !full || merge_hit;

  assign bus_addr  = {ent_addr[head], 2'b00};
  assign bus_we    = ent_we[head];
  assign bus_wdata = ent_data[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
    end else begin
      if (enq) begin
        tail            <= tail + PTR_W'(1);
        ent_valid[tail] <= 1'b1;
      end
      if (deq) begin
        head            <= head + PTR_W'(1);
        ent_valid[head] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= st_addr[31:2];
      ent_we[tail]   <= st_we;
      ent_data[tail] <= st_data;
    end else if (merge_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (st_we[b]) begin
          ent_data[tail_m1][8*b +: 8] <= st_data[8*b +: 8];
          ent_we[tail_m1][b]          <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer_ctrl;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [3:0]       st_we;
  logic [31:0]      st_data;
  logic             st_ready;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic             ld_grant;
  logic             ld_stall;
  logic             drain_req;
  logic             drain_busy;
  logic             bus_wvalid;
  logic [31:0]      bus_addr;
  logic [3:0]       bus_we;
  logic [31:0]      bus_wdata;
  logic             bus_wready;
  logic [PTR_W:0]   count;
  logic             empty;

  store_buffer_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_we(st_we), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_grant(ld_grant), .ld_stall(ld_stall),
    .drain_req(drain_req), .drain_busy(drain_busy),
    .bus_wvalid(bus_wvalid), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_wready(bus_wready), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  we;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic m_full, m_conf, m_grant, m_wvalid, m_deq, m_merge, m_enq, m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules in queue terms: q[0] is the head, q[$] the newest entry.
  task automatic eval();
    int n;
    n = q.size();
    m_full = (n == DEPTH);
    m_conf = 1'b0;
    foreach (q[i]) if (ld_valid && q[i].wa == ld_addr[31:2]) m_conf = 1'b1;
    m_grant  = ld_valid && !m_conf && !m_full;
    m_wvalid = (n != 0) && !m_grant;
    m_deq    = m_wvalid && bus_wready;
    m_merge  = st_valid && (n != 0) && (q[n-1].wa == st_addr[31:2]) && !(n == 1 && m_wvalid);
    m_enq    = st_valid && !m_full && !m_merge;
    m_ready  = !m_full || m_merge;
  endtask

  task automatic compare_all();
    eval();
    chk("st_ready",   32'(st_ready),   32'(m_ready));
    chk("ld_grant",   32'(ld_grant),   32'(m_grant));
    chk("ld_stall",   32'(ld_stall),   32'(ld_valid && !m_grant));
    chk("drain_busy", 32'(drain_busy), 32'(drain_req && q.size() != 0));
    chk("bus_wvalid", 32'(bus_wvalid), 32'(m_wvalid));
    chk("count",      32'(count),      32'(q.size()));
    chk("empty",      32'(empty),      32'(q.size() == 0));
    if (m_wvalid) begin
      chk("bus_addr",  bus_addr,       {q[0].wa, 2'b00});
      chk("bus_we",    32'(bus_we),    32'(q[0].we));
      chk("bus_wdata", bus_wdata,      q[0].data);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    ent_t e;
    if (m_merge) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++) begin
        if (st_we[b]) begin
          e.we[b] = 1'b1;
          e.data[8*b +: 8] = st_data[8*b +: 8];
        end
      end
      q[q.size()-1] = e;
    end
    if (m_deq) void'(q.pop_front());
    if (m_enq) begin
      e.wa = st_addr[31:2];
      e.we = st_we;
      e.data = st_data;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_we    = w;
    st_data  = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    set_st(1'b1, a, w, d);
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    drain_req = 1'b0;
    bus_wready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    sample();
    chk("drain_empty", 32'(empty), 32'd1);
    advance();
  endtask

  initial begin
    reset = 1'b1;
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b0;
    ld_addr = 32'h0;
    drain_req = 1'b0;
    bus_wready = 1'b0;
    #3;
    chk("rst_count",    32'(count),      32'd0);
    chk("rst_empty",    32'(empty),      32'd1);
    chk("rst_wvalid",   32'(bus_wvalid), 32'd0);
    chk("rst_st_ready", 32'(st_ready),   32'd1);
    chk("rst_ld_grant", 32'(ld_grant),   32'd0);
    chk("rst_ld_stall", 32'(ld_stall),   32'd0);
    chk("rst_drain",    32'(drain_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-operation
    store(32'h0000_0000, 4'hF, 32'h0000_0001);
    store(32'h0000_0004, 4'hF, 32'h0000_0002);
    store(32'h0000_0008, 4'hF, 32'h0000_0003);
    chk("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_count",  32'(count),      32'd0);
    chk("async_rst_empty",  32'(empty),      32'd1);
    chk("async_rst_wvalid", 32'(bus_wvalid), 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus_wready = 1'b1;
    set_st(1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344);
    sample();
    chk("t1_wvalid_same_cycle", 32'(bus_wvalid), 32'd0);
    advance();
    st_valid = 1'b0;
    sample();
    chk("t1_wvalid", 32'(bus_wvalid), 32'd1);
    chk("t1_addr",   bus_addr,        32'h0000_0010);
    chk("t1_data",   bus_wdata,       32'h1122_3344);
    advance();
    drain_all();

    // Merge into a non-head tail entry
    bus_wready = 1'b0;
    store(32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
    store(32'h0000_0024, 4'b0001, 32'h0000_00AA);
    set_st(1'b1, 32'h0000_0026, 4'b0100, 32'h00BB_0000);
    sample();
    chk("t2_merge_ready", 32'(st_ready), 32'd1);
    advance();
    st_valid = 1'b0;
    sample();
    chk("t2_count", 32'(count), 32'd2);
    advance();
    bus_wready = 1'b1;
    tick();
    sample();
    chk("t2_addr", bus_addr,       32'h0000_0024);
    chk("t2_we",   32'(bus_we),    32'h5);
    chk("t2_data", bus_wdata,      32'h00BB_00AA);
    advance();
    drain_all();

    // Full and wrap, twice
    for (int r = 0; r < 2; r++) begin
      bus_wready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        set_st(1'b1, 32'h0000_0100 + 32'(16*r + 4*i), 4'hF, 32'hA000_0000 + 32'(16*r + i));
        sample();
        if (i == 4) begin
          chk("t3_full_ready", 32'(st_ready), 32'd0);
          chk("t3_full_count", 32'(count),    32'd4);
        end
        advance();
      end
      st_valid = 1'b0;
      bus_wready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        sample();
        chk("t3_order", bus_addr, 32'h0000_0100 + 32'(16*r + 4*i));
        advance();
      end
      sample();
      chk("t3_empty", 32'(empty), 32'd1);
      advance();
    end

    // Load conflict with a pending store
    bus_wready = 1'b0;
    store(32'h0000_7f04, 4'hF, 32'h0000_0055);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_7f06;
    sample();
    chk("t4_stall", 32'(ld_stall), 32'd1);
    advance();
    bus_wready = 1'b1;
    sample();
    chk("t4_stall2", 32'(ld_stall),   32'd1);
    chk("t4_wv",     32'(bus_wvalid), 32'd1);
    advance();
    sample();
    chk("t4_grant_after", 32'(ld_grant), 32'd1);
    chk("t4_nostall",     32'(ld_stall), 32'd0);
    advance();
    ld_valid = 1'b0;
    bus_wready = 1'b0;
    store(32'h0000_7f04, 4'hF, 32'h0000_0066);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_7f14;
    sample();
    chk("t4_grant_free", 32'(ld_grant),   32'd1);
    chk("t4_wv_blocked", 32'(bus_wvalid), 32'd0);
    advance();
    drain_all();

    // Full buffer with a non-conflicting load
    bus_wready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h0000_0200 + 32'(4*i), 4'hF, 32'(i));
    bus_wready = 1'b1;
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_7f20;
    sample();
    chk("t5_stall", 32'(ld_stall),   32'd1);
    chk("t5_wv",    32'(bus_wvalid), 32'd1);
    advance();
    sample();
    chk("t5_grant", 32'(ld_grant),   32'd1);
    chk("t5_wv0",   32'(bus_wvalid), 32'd0);
    advance();
    drain_all();

    // Drain request
    bus_wready = 1'b0;
    store(32'h0000_0300, 4'hF, 32'h1);
    store(32'h0000_0304, 4'hF, 32'h2);
    drain_req = 1'b1;
    bus_wready = 1'b1;
    sample();
    chk("t6_busy0", 32'(drain_busy), 32'd1);
    advance();
    sample();
    chk("t6_busy1", 32'(drain_busy), 32'd1);
    advance();
    sample();
    chk("t6_idle",  32'(drain_busy), 32'd0);
    chk("t6_empty", 32'(empty),      32'd1);
    advance();
    drain_req = 1'b0;

    // Randomized traffic over a small address pool to provoke merges and conflicts
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pool [8];
      logic [3:0]  w;
      pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0004; pool[2] = 32'h0000_0008;
      pool[3] = 32'h0000_2ffc; pool[4] = 32'h0000_7f00; pool[5] = 32'h0000_7f10;
      pool[6] = 32'h0000_7f20; pool[7] = 32'h0000_000c;
      w = 4'($urandom_range(1, 15));
      set_st(($urandom_range(0, 99) < 60), pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
             w, $urandom);
      ld_valid   = ($urandom_range(0, 99) < 35);
      ld_addr    = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      bus_wready = ($urandom_range(0, 99) < 45);
      drain_req  = ($urandom_range(0, 99) < 10);
      if (drain_req && q.size() != 0) st_valid = 1'b0;
      tick();
    end
    st_valid = 1'b0;
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
